// File: rtl/mulmod_3529_seq_pkg.sv
// Shared constants for the mod-3529 datapath.
//   Q    : modulus, held at W+1 bits so sums below 2Q compare without extension
//   W    : operand/result width
//   CW   : iteration counter width
//   ST_* : controller state encoding
package mulmod_3529_seq_pkg;

   localparam int W  = 12;
   localparam int CW = 4;

   localparam logic [W:0] Q = 13'd3529;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mod_add_sub_3529.sv
// Combinational modular add: s = (x + y) mod Q for x, y < Q.
// Ports:
//   x, y : addends, each already below Q
//   s    : reduced sum, below Q
module mod_add_sub_3529
   import mulmod_3529_seq_pkg::*;
(
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] s
);

   logic [W:0] sum;
   logic       ge_q;

   assign sum  = {1'b0, x} + {1'b0, y};
   assign ge_q = (sum >= Q);

   // The reduced value is below 2**W, so wrapping W-bit arithmetic is exact.
   assign s = sum[W-1:0] - (ge_q ? Q[W-1:0] : '0);

endmodule

// File: rtl/mulmod_3529_seq.sv
// Iterative modular multiplier: dout_r = (din_a * din_b) mod 3529.
// MSB-first shift-add with a reduction after every double and every add,
// so no full-width product is ever formed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   din_a, din_b        : operands, any 12-bit value
//   out_valid/out_ready : result handshake
//   dout_r              : reduced result, held after it is consumed
//
//   state   | meaning
//   IDLE    | waiting for operands
//   RUN     | processing one multiplier bit per cycle, MSB first
//   DONE    | result presented, waiting for out_ready
module mulmod_3529_seq
   import mulmod_3529_seq_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] din_a,
   input  logic [W-1:0] din_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] dout_r
);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  acc;
   logic [W-1:0]  dbl;
   logic [W-1:0]  dbl_add;
   logic [W-1:0]  step;

   assign in_ready  = (state == ST_IDLE) && !rst;
   assign out_valid = (state == ST_DONE);

   mod_add_sub_3529 u_dbl (
      .x (acc),
      .y (acc),
      .s (dbl)
   );

   mod_add_sub_3529 u_add (
      .x (dbl),
      .y (a_q),
      .s (dbl_add)
   );

   assign step = b_q[cnt] ? dbl_add : dbl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         acc    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         dout_r <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  // 4095 < 2Q, so a single subtract fully reduces a.
                  a_q   <= (din_a >= Q[W-1:0]) ? din_a - Q[W-1:0] : din_a;
                  // b only steers the loop bit by bit, so it stays unreduced.
                  b_q   <= din_b;
                  acc   <= '0;
                  cnt   <= CW'(W - 1);
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               acc <= step;
               if (cnt == '0) begin
                  dout_r <= step;
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mulmod_3529_seq.sv
module tb_mulmod_3529_seq;
   import mulmod_3529_seq_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] din_a;
   logic [W-1:0] din_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] dout_r;

   int checks = 0;
   int errors = 0;

   mulmod_3529_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din_a     (din_a),
      .din_b     (din_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout_r    (dout_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Presents operands, waits for the result and checks it. With consume=1
   // out_ready is already high and the result is taken on the next edge.
   task automatic op(input string tag, input int a, input int b, input int exp_r,
                     input int exp_lat, input bit consume);
      int wait_cnt;
      int lat;
      wait_cnt = 0;
      @(negedge clk);
      while (!in_ready && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      check({tag, "_in_ready"}, int'(in_ready), 1);
      din_a    = W'(a);
      din_b    = W'(b);
      in_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      in_valid = 1'b0;
      din_a    = W'($urandom);
      din_b    = W'($urandom);
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
      end
      if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_dout_r"}, int'(dout_r), exp_r);
      if (consume) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         check({tag, "_consumed"}, int'(out_valid), 0);
      end
   endtask

   initial begin
      int a;
      int b;
      int hold;
      bit spurious;
      logic [W-1:0] held_r;

      rst       = 1'b1;
      in_valid  = 1'b0;
      din_a     = '0;
      din_b     = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_dout_r", int'(dout_r), 0);
      check("rst_in_ready", int'(in_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("idle_in_ready", int'(in_ready), 1);

      // Basic products and latency
      op("zero_a", 0, 1234, 0, 13, 1'b1);
      op("minus1_sq", 3528, 3528, 1, 13, 1'b1);
      op("p1234x2345", 1234, 2345, 3479, 0, 1'b1);
      op("p2x1765", 2, 1765, 1, 0, 1'b1);

      // Out-of-range operands
      op("a4095", 4095, 1, 566, 0, 1'b1);
      op("b4095", 1, 4095, 566, 0, 1'b1);
      op("ab4095", 4095, 4095, 2746, 0, 1'b1);
      op("max_b_bit", 1, 2048, 2048, 0, 1'b1);

      // Backpressure: result held, new operands ignored while DONE
      out_ready = 1'b0;
      op("bp", 1234, 2345, 3479, 13, 1'b0);
      held_r = dout_r;
      @(negedge clk);
      din_a    = 12'd7;
      din_b    = 12'd9;
      in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", int'(out_valid), 1);
         check("bp_in_ready", int'(in_ready), 0);
         check("bp_dout_r", int'(dout_r), int'(held_r));
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_consumed", int'(out_valid), 0);
      check("bp_dout_kept", int'(dout_r), 3479);
      check("bp_in_ready_after", int'(in_ready), 1);

      // Reset on the sixth RUN cycle
      @(negedge clk);
      din_a    = 12'd1000;
      din_b    = 12'd1000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_run_out_valid", int'(out_valid), 0);
      check("rst_run_in_ready", int'(in_ready), 0);
      check("rst_run_dout_r", int'(dout_r), 0);
      rst = 1'b0;
      #1;
      check("rst_run_in_ready_after", int'(in_ready), 1);
      spurious = 1'b0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (out_valid) spurious = 1'b1;
      end
      check("rst_run_no_spurious", int'(spurious), 0);
      op("after_rst", 3528, 2, 3527, 13, 1'b1);

      // Random operands with random output stalls, against a reference model
      for (int i = 0; i < 150; i++) begin
         a    = int'($urandom_range(0, 4095));
         b    = int'($urandom_range(0, 4095));
         hold = int'($urandom_range(0, 3));
         out_ready = (hold == 0);
         op("rand", a, b, (a * b) % 3529, 0, 1'b0);
         repeat (hold) @(posedge clk);
         #1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         check("rand_consumed", int'(out_valid), 0);
         repeat (int'($urandom_range(0, 2))) @(posedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
